simple_mac_rx: RTL and testbench

MII receive-side MAC for the Ethernet path. It runs entirely on eth_rxclk and accepts nibbles from the PHY. It strips the preamble and SFD, assembles bytes low nibble first, checks the FCS with an inline CRC32, and strips the 4 FCS bytes before output. Output is a registered byte stream with sop/eop/err framing for the downstream packet parser. The MII cannot be stalled, so there is no backpressure.

---
 rtl/simple_mac_rx.sv | 162 ++++++++++++++++
 tb/tb_simple_mac_rx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/simple_mac_rx.sv
// MII receive MAC: strips preamble/SFD, assembles bytes, checks the FCS, drops it on output.
// Define RX_STATS_EN to add the rx_frame_cnt / rx_bad_cnt statistics ports.
module simple_mac_rx #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518
) (
  input  logic        eth_rxclk,
  input  logic        rstn,
  input  logic        eth_rxdv,
  input  logic        eth_rxer,
  input  logic [3:0]  eth_rxd,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic        rx_err,
  output logic        rx_crc_err,
  output logic        rx_busy
`ifdef RX_STATS_EN
  ,
  output logic [31:0] rx_frame_cnt,
  output logic [31:0] rx_bad_cnt
`endif
);

  localparam int CW = $clog2(MAX_FRAME + 2);
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

  state_t          state;
  logic            phase;
  logic [3:0]      low_nib;
  logic [31:0]     crc;
  logic [CW-1:0]   cnt;
  logic [4:0][7:0] dline;
  logic            rxer_seen;

  logic [7:0]      byte_in;
  logic [CW-1:0]   cnt_next;
  logic [31:0]     crc_next;
  logic            crc_bad;

  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int unsigned i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  always_comb begin
    byte_in  = {eth_rxd, low_nib};
    cnt_next = cnt + 1'b1;
    crc_next = crc_byte(crc, byte_in);
    crc_bad  = (crc != CRC_RESIDUE);
  end

  assign rx_busy = (state == PREAMBLE) || (state == DATA);

  always_ff @(posedge eth_rxclk or negedge rstn) begin
    if (!rstn) begin
      state      <= DROP;
      phase      <= 1'b0;
      low_nib    <= '0;
      crc        <= '1;
      cnt        <= '0;
      dline      <= '0;
      rxer_seen  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_sop     <= 1'b0;
      rx_eop     <= 1'b0;
      rx_err     <= 1'b0;
      rx_crc_err <= 1'b0;
`ifdef RX_STATS_EN
      rx_frame_cnt <= '0;
      rx_bad_cnt   <= '0;
`endif
    end else begin
      rx_valid   <= 1'b0;
      rx_sop     <= 1'b0;
      rx_eop     <= 1'b0;
      rx_err     <= 1'b0;
      rx_crc_err <= 1'b0;
      case (state)
        IDLE: begin
          if (eth_rxdv) begin
            state     <= (eth_rxd == 4'h5) ? PREAMBLE : DROP;
            rxer_seen <= eth_rxer;
          end
        end
        PREAMBLE: begin
          if (!eth_rxdv) begin
            state <= IDLE;
          end else begin
            if (eth_rxer) rxer_seen <= 1'b1;
            if (eth_rxd == 4'hD) begin
              state <= DATA;
              phase <= 1'b0;
              crc   <= '1;
              cnt   <= '0;
            end else if (eth_rxd != 4'h5) begin
              state <= DROP;
            end
          end
        end
        DATA: begin
          if (eth_rxdv) begin
            if (eth_rxer) rxer_seen <= 1'b1;
            if (!phase) begin
              low_nib <= eth_rxd;
              phase   <= 1'b1;
            end else begin
              phase <= 1'b0;
              crc   <= crc_next;
              cnt   <= cnt_next;
              dline <= {dline[3:0], byte_in};
              // dline[4] is byte n-5: always payload while the frame is running
              if (cnt_next > CW'(5)) begin
                rx_valid <= 1'b1;
                rx_data  <= dline[4];
                rx_sop   <= (cnt_next == CW'(6));
                if (cnt_next == CW'(MAX_FRAME + 1)) begin
                  rx_eop <= 1'b1;
                  rx_err <= 1'b1;
                  state  <= DROP;
`ifdef RX_STATS_EN
                  rx_frame_cnt <= rx_frame_cnt + 1'b1;
                  rx_bad_cnt   <= rx_bad_cnt + 1'b1;
`endif
                end
              end
            end
          end else begin
            state <= IDLE;
            // Frame end: dline holds the last payload byte followed by the 4 FCS bytes
            if (cnt >= CW'(5)) begin
              rx_valid   <= 1'b1;
              rx_data    <= dline[4];
              rx_sop     <= (cnt == CW'(5));
              rx_eop     <= 1'b1;
              rx_crc_err <= crc_bad;
              rx_err     <= crc_bad | rxer_seen | phase | (cnt < CW'(MIN_FRAME));
`ifdef RX_STATS_EN
              rx_frame_cnt <= rx_frame_cnt + 1'b1;
              if (crc_bad | rxer_seen | phase | (cnt < CW'(MIN_FRAME)))
                rx_bad_cnt <= rx_bad_cnt + 1'b1;
            end else begin
              rx_bad_cnt <= rx_bad_cnt + 1'b1;
`endif
            end
          end
        end
        default: begin
          if (!eth_rxdv) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_simple_mac_rx.sv
// Randomized self-checking bench for simple_mac_rx against a frame-level reference model.
// Build with +define+RX_STATS_EN to also check the statistics counters.
module tb_simple_mac_rx;

  localparam int MIN_FRAME = 64;
  localparam int MAX_FRAME = 1518;

  logic        eth_rxclk = 1'b0;
  logic        rstn      = 1'b0;
  logic        eth_rxdv  = 1'b0;
  logic        eth_rxer  = 1'b0;
  logic [3:0]  eth_rxd   = 4'h0;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sop, rx_eop, rx_err, rx_crc_err, rx_busy;
`ifdef RX_STATS_EN
  logic [31:0] rx_frame_cnt, rx_bad_cnt;
`endif

  simple_mac_rx #(.MIN_FRAME(MIN_FRAME), .MAX_FRAME(MAX_FRAME)) dut (
    .eth_rxclk (eth_rxclk),
    .rstn      (rstn),
    .eth_rxdv  (eth_rxdv),
    .eth_rxer  (eth_rxer),
    .eth_rxd   (eth_rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_sop    (rx_sop),
    .rx_eop    (rx_eop),
    .rx_err    (rx_err),
    .rx_crc_err(rx_crc_err),
    .rx_busy   (rx_busy)
`ifdef RX_STATS_EN
    ,
    .rx_frame_cnt(rx_frame_cnt),
    .rx_bad_cnt  (rx_bad_cnt)
`endif
  );

  always #5 eth_rxclk = ~eth_rxclk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output beats: {data, sop, eop, err, crc_err}
  logic [11:0] exp_q[$];
  int unsigned exp_frames = 0;
  int unsigned exp_bad    = 0;
  logic [7:0]  pay[$];

  function automatic logic [31:0] fcs_of(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  always @(negedge eth_rxclk) begin
    if (!rstn) begin
      chk("reset_outputs", {rx_valid, rx_sop, rx_eop, rx_err, rx_crc_err, rx_busy, rx_data}, 32'h0);
    end else if (rx_valid) begin
      if (exp_q.size() == 0) chk("unexpected_byte", exp_q.size(), 32'd1);
      else chk("byte", {rx_data, rx_sop, rx_eop, rx_err, rx_crc_err}, exp_q.pop_front());
    end else begin
      chk("flags_without_valid", {rx_sop, rx_eop, rx_err, rx_crc_err}, 32'h0);
    end
  end

  task automatic make_payload(input int len, input bit counting);
    pay.delete();
    for (int i = 0; i < len; i++) pay.push_back(counting ? 8'(i) : 8'($urandom));
  endtask

  // Sends pay + FCS; rxer_at / rst_at < 0 disable those events
  task automatic send_frame(input bit flip, input int rxer_at, input bit extra,
                            input int rst_at, input int pre_len);
    logic [7:0]  b[$];
    logic [31:0] fcs;
    int          n, last;
    bit          crc_bad, err;
    b   = pay;
    fcs = fcs_of(pay);
    if (flip) fcs[0] = ~fcs[0];
    for (int i = 0; i < 4; i++) b.push_back(fcs[8*i +: 8]);
    n       = b.size();
    crc_bad = (fcs != fcs_of(pay));
    if (rst_at >= 0) begin
      for (int i = 0; i <= rst_at - 6; i++) exp_q.push_back({b[i], (i == 0), 3'b000});
    end else if (n > MAX_FRAME) begin
      last = MAX_FRAME - 5;
      for (int i = 0; i <= last; i++)
        exp_q.push_back({b[i], (i == 0), (i == last), (i == last), 1'b0});
      exp_frames++;
      exp_bad++;
    end else if (n >= 5) begin
      last = n - 5;
      err  = crc_bad || (rxer_at >= 0 && rxer_at < n) || extra || (n < MIN_FRAME);
      for (int i = 0; i <= last; i++)
        exp_q.push_back({b[i], (i == 0), (i == last), (i == last) && err, (i == last) && crc_bad});
      exp_frames++;
      if (err) exp_bad++;
    end else begin
      exp_bad++;
    end

    eth_rxdv = 1'b1;
    eth_rxd  = 4'h5;
    repeat (pre_len) @(negedge eth_rxclk);
    eth_rxd = 4'hD;
    @(negedge eth_rxclk);
    for (int i = 0; i < n; i++) begin
      for (int nib = 0; nib < 2; nib++) begin
        eth_rxd  = (nib == 1) ? b[i][7:4] : b[i][3:0];
        eth_rxer = (i == rxer_at) && (nib == 0);
        if (nib == 0 && i == rst_at) begin
          #2 rstn = 1'b0;
          exp_frames = 0;
          exp_bad    = 0;
        end
        if (nib == 0 && rst_at >= 0 && i == rst_at + 1) #2 rstn = 1'b1;
        @(negedge eth_rxclk);
      end
    end
    eth_rxer = 1'b0;
    if (extra) begin
      eth_rxd = 4'($urandom);
      @(negedge eth_rxclk);
    end
    eth_rxdv = 1'b0;
    repeat (3) @(negedge eth_rxclk);
    chk("frame_drained", exp_q.size(), 32'd0);
    exp_q.delete();
    chk("busy_after_frame", rx_busy, 32'd0);
`ifdef RX_STATS_EN
    chk("frame_cnt", rx_frame_cnt, exp_frames);
    chk("bad_cnt", rx_bad_cnt, exp_bad);
`endif
    repeat ($urandom_range(0, 2)) @(negedge eth_rxclk);
  endtask

  initial begin
    repeat (3) @(negedge eth_rxclk);
    chk("reset_state", {rx_valid, rx_sop, rx_eop, rx_err, rx_crc_err, rx_busy}, 32'h0);
    rstn = 1'b1;
    repeat (3) @(negedge eth_rxclk);

    make_payload(60, 1'b1);  send_frame(1'b0, -1, 1'b0, -1, 15);
    make_payload(60, 1'b1);  send_frame(1'b1, -1, 1'b0, -1, 15);
    make_payload(20, 1'b1);  send_frame(1'b0, -1, 1'b0, -1, 15);
    make_payload(60, 1'b1);  send_frame(1'b0, 30, 1'b0, -1, 15);
    make_payload(60, 1'b1);  send_frame(1'b0, -1, 1'b1, -1, 15);
    make_payload(1596, 1'b0); send_frame(1'b0, -1, 1'b0, -1, 15);
    make_payload(60, 1'b0);  send_frame(1'b0, -1, 1'b0, -1, 15);
    make_payload(60, 1'b0);  send_frame(1'b0, -1, 1'b0, 25, 15);
    make_payload(60, 1'b0);  send_frame(1'b0, -1, 1'b0, -1, 15);

    // Length boundaries: 4, 5, 6 total bytes, MIN-1, MIN, MAX and MAX+1
    make_payload(0, 1'b0);               send_frame(1'b0, -1, 1'b0, -1, 7);
    make_payload(1, 1'b0);               send_frame(1'b0, -1, 1'b0, -1, 7);
    make_payload(2, 1'b0);               send_frame(1'b0, -1, 1'b0, -1, 7);
    make_payload(MIN_FRAME - 5, 1'b0);   send_frame(1'b0, -1, 1'b0, -1, 7);
    make_payload(MIN_FRAME - 4, 1'b0);   send_frame(1'b0, -1, 1'b0, -1, 7);
    make_payload(MAX_FRAME - 4, 1'b0);   send_frame(1'b0, -1, 1'b0, -1, 1);
    make_payload(MAX_FRAME - 3, 1'b0);   send_frame(1'b0, -1, 1'b0, -1, 1);

    for (int f = 0; f < 30; f++) begin
      int len, rx_at;
      len   = $urandom_range(0, 100);
      rx_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, len + 3)) : -1;
      make_payload(len, 1'b0);
      send_frame(($urandom_range(0, 3) == 0), rx_at, ($urandom_range(0, 7) == 0), -1,
                 $urandom_range(1, 15));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
